// File: rtl/cu_read_tag_responder_pkg.sv
// Shared line formats and per-tag bookkeeping for the CU read-command path.
package cu_read_tag_responder_pkg;

  localparam int TAG_COUNT_GLOBAL = 32;
  localparam int DATA_WIDTH       = 512;

  typedef struct packed {
    logic        valid;
    logic [7:0]  cu_id;
    logic [7:0]  cmd;
    logic [7:0]  tag;
    logic [11:0] size;
    logic [63:0] address;
  } CommandBufferLine;

  typedef struct packed {
    logic full;
    logic empty;
  } BufferStatus;

  typedef struct packed {
    logic        valid;
    logic [7:0]  cu_id;
    logic [7:0]  cmd;
    logic [7:0]  tag;
    logic [11:0] size;
    logic [63:0] address;
    logic [7:0]  response;
  } ResponseBufferLine;

  typedef struct packed {
    logic                  valid;
    logic [7:0]            cu_id;
    logic [7:0]            cmd;
    logic [7:0]            tag;
    logic [63:0]           address;
    logic                  data_index;
    logic [DATA_WIDTH-1:0] data;
  } ReadWriteDataLine;

  typedef struct packed {
    logic [7:0]  cu_id;
    logic [7:0]  cmd;
    logic [11:0] size;
    logic [63:0] address;
  } tag_entry_type;

  function automatic tag_entry_type make_entry(CommandBufferLine c);
    tag_entry_type e;
    e.cu_id   = c.cu_id;
    e.cmd     = c.cmd;
    e.size    = c.size;
    e.address = c.address;
    return e;
  endfunction

endpackage

// File: rtl/cu_read_tag_responder_free_fifo.sv
// Circular FIFO holding free tags; push and pop in the same cycle both take effect.
module cu_tag_free_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         rstn_in,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_data_o,
  output logic [W:0]   count_o,
  output logic         empty_o,
  output logic         full_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] wr_ptr_q, rd_ptr_q;
  logic [W:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == (W+1)'(DEPTH));
  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers are W bits wide over a power-of-two depth, so they wrap naturally.
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cu_read_tag_responder.sv
// Tags CU read commands from a free pool, forwards them to the PSL, and restores
// the original command fields onto returning data beats and responses.
module cu_read_tag_responder
  import cu_read_tag_responder_pkg::*;
#(
  parameter int TAG_COUNT   = TAG_COUNT_GLOBAL,
  parameter int TAG_WIDTH   = $clog2(TAG_COUNT),
  parameter int FULL_MARGIN = 2
) (
  input  logic              clock,
  input  logic              rstn_in,
  input  logic              enabled_in,
  input  CommandBufferLine  read_command_in,
  output BufferStatus       read_buffer_status,
  output CommandBufferLine  psl_command_out,
  input  ResponseBufferLine psl_response_in,
  input  ReadWriteDataLine  psl_data_in,
  output ResponseBufferLine read_response_out,
  output ReadWriteDataLine  read_data_0_out,
  output ReadWriteDataLine  read_data_1_out,
  output logic [TAG_WIDTH:0] outstanding_count,
  output logic              tag_error
);

  tag_entry_type          tag_table_q [TAG_COUNT];
  logic [TAG_COUNT-1:0]   outst_q, outst_d;
  logic [TAG_WIDTH-1:0]   init_cnt_q;
  logic                   init_done_q;
  logic [TAG_WIDTH:0]     out_cnt_q, out_cnt_d;
  logic                   err_q;

  logic [TAG_WIDTH-1:0]   alloc_tag, push_tag, rsp_idx, dat_idx;
  logic [TAG_WIDTH:0]     free_count;
  logic                   fifo_empty, fifo_full, fifo_push;
  logic                   accept, cmd_drop, rsp_hit, rsp_stale, dat_hit, dat_stale;

  CommandBufferLine       cmd_d;
  ResponseBufferLine      rsp_d;
  ReadWriteDataLine       beat, d0_d, d1_d;
  BufferStatus            status_d;
  tag_entry_type          rsp_ent, dat_ent;

  assign accept   = read_command_in.valid && enabled_in && init_done_q && !fifo_empty;
  assign cmd_drop = read_command_in.valid && enabled_in && init_done_q && fifo_empty;

  assign rsp_idx   = psl_response_in.tag[TAG_WIDTH-1:0];
  assign dat_idx   = psl_data_in.tag[TAG_WIDTH-1:0];
  assign rsp_hit   = psl_response_in.valid && (int'(psl_response_in.tag) < TAG_COUNT)
                     && outst_q[rsp_idx];
  assign rsp_stale = psl_response_in.valid && !rsp_hit;
  assign dat_hit   = psl_data_in.valid && (int'(psl_data_in.tag) < TAG_COUNT)
                     && outst_q[dat_idx];
  assign dat_stale = psl_data_in.valid && !dat_hit;

  // Init fills the pool first; no tag can be outstanding until it finishes.
  assign fifo_push = !init_done_q || rsp_hit;
  assign push_tag  = init_done_q ? rsp_idx : init_cnt_q;

  cu_tag_free_fifo #(.DEPTH(TAG_COUNT), .W(TAG_WIDTH)) u_free_fifo (
    .clock       (clock),
    .rstn_in     (rstn_in),
    .push_i      (fifo_push),
    .push_data_i (push_tag),
    .pop_i       (accept),
    .pop_data_o  (alloc_tag),
    .count_o     (free_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  always_comb begin
    outst_d = outst_q;
    if (accept)  outst_d[alloc_tag] = 1'b1;
    if (rsp_hit) outst_d[rsp_idx]   = 1'b0;

    out_cnt_d = out_cnt_q;
    if (accept && !rsp_hit)      out_cnt_d = out_cnt_q + 1'b1;
    else if (!accept && rsp_hit) out_cnt_d = out_cnt_q - 1'b1;

    cmd_d = '0;
    if (accept) begin
      cmd_d     = read_command_in;
      cmd_d.tag = 8'(alloc_tag);
    end

    rsp_ent = tag_table_q[rsp_idx];
    rsp_d   = '0;
    if (rsp_hit) begin
      rsp_d         = psl_response_in;
      rsp_d.cu_id   = rsp_ent.cu_id;
      rsp_d.cmd     = rsp_ent.cmd;
      rsp_d.size    = rsp_ent.size;
      rsp_d.address = rsp_ent.address;
    end

    dat_ent      = tag_table_q[dat_idx];
    beat         = psl_data_in;
    beat.cu_id   = dat_ent.cu_id;
    beat.cmd     = dat_ent.cmd;
    beat.address = dat_ent.address;
    d0_d = (dat_hit && !beat.data_index) ? beat : '0;
    d1_d = (dat_hit &&  beat.data_index) ? beat : '0;

    status_d.full  = (int'(free_count) <= FULL_MARGIN) || !init_done_q || !enabled_in;
    status_d.empty = (out_cnt_q == '0);
  end

  always_ff @(posedge clock) begin
    if (accept) tag_table_q[alloc_tag] <= make_entry(read_command_in);
  end

  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      init_cnt_q         <= '0;
      init_done_q        <= 1'b0;
      outst_q            <= '0;
      out_cnt_q          <= '0;
      err_q              <= 1'b0;
      psl_command_out    <= '0;
      read_response_out  <= '0;
      read_data_0_out    <= '0;
      read_data_1_out    <= '0;
      read_buffer_status <= '{full: 1'b1, empty: 1'b1};
    end else begin
      if (!init_done_q) begin
        init_cnt_q  <= init_cnt_q + 1'b1;
        init_done_q <= (init_cnt_q == TAG_WIDTH'(TAG_COUNT - 1));
      end
      outst_q            <= outst_d;
      out_cnt_q          <= out_cnt_d;
      if (cmd_drop || rsp_stale || dat_stale) err_q <= 1'b1;
      psl_command_out    <= cmd_d;
      read_response_out  <= rsp_d;
      read_data_0_out    <= d0_d;
      read_data_1_out    <= d1_d;
      read_buffer_status <= status_d;
    end
  end

  assign outstanding_count = out_cnt_q;
  assign tag_error         = err_q;

endmodule

// File: tb/tb_cu_read_tag_responder.sv
// Directed bench for the CU read tag responder: init, round trip, exhaustion,
// simultaneous accept/release, stale tags, mid-run reset and enable gating.
module tb_cu_read_tag_responder;
  import cu_read_tag_responder_pkg::*;

  logic              clock = 1'b0;
  logic              rstn_in = 1'b0;
  logic              enabled_in = 1'b0;
  CommandBufferLine  read_command_in;
  BufferStatus       read_buffer_status;
  CommandBufferLine  psl_command_out;
  ResponseBufferLine psl_response_in;
  ReadWriteDataLine  psl_data_in;
  ResponseBufferLine read_response_out;
  ReadWriteDataLine  read_data_0_out, read_data_1_out;
  logic [5:0]        outstanding_count;
  logic              tag_error;

  int checks = 0;
  int failures = 0;

  cu_read_tag_responder dut (
    .clock              (clock),
    .rstn_in            (rstn_in),
    .enabled_in         (enabled_in),
    .read_command_in    (read_command_in),
    .read_buffer_status (read_buffer_status),
    .psl_command_out    (psl_command_out),
    .psl_response_in    (psl_response_in),
    .psl_data_in        (psl_data_in),
    .read_response_out  (read_response_out),
    .read_data_0_out    (read_data_0_out),
    .read_data_1_out    (read_data_1_out),
    .outstanding_count  (outstanding_count),
    .tag_error          (tag_error)
  );

  always #5 clock = ~clock;

  task step();
    @(posedge clock);
    #1;
  endtask

  task clear_inputs();
    read_command_in = '0;
    psl_response_in = '0;
    psl_data_in     = '0;
  endtask

  task set_cmd(input logic [63:0] addr, input logic [7:0] cu);
    read_command_in         = '0;
    read_command_in.valid   = 1'b1;
    read_command_in.address = addr;
    read_command_in.cu_id   = cu;
    read_command_in.cmd     = 8'h10;
    read_command_in.size    = 12'd128;
    read_command_in.tag     = 8'hEE;
  endtask

  task set_rsp(input logic [7:0] tag, input logic [7:0] code);
    psl_response_in          = '0;
    psl_response_in.valid    = 1'b1;
    psl_response_in.tag      = tag;
    psl_response_in.response = code;
  endtask

  task reset_dut();
    rstn_in    = 1'b0;
    enabled_in = 1'b1;
    clear_inputs();
    step();
    step();
    rstn_in = 1'b1;
  endtask

  // 32 cycles of init; full must stay high through all of them.
  task wait_init();
    int bad = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (read_buffer_status.full !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL init_full: full low in %0d of 32 init cycles, required 0", bad);
    end
  endtask

  task issue_n(input int n);
    for (int i = 0; i < n; i++) begin
      set_cmd(64'h2000 + 64'(i), 8'd1);
      step();
    end
    clear_inputs();
  endtask

  task test_reset();
    rstn_in = 1'b0;
    clear_inputs();
    step();
    checks++;
    if (psl_command_out !== '0 || read_response_out !== '0 ||
        read_data_0_out !== '0 || read_data_1_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs: cmd.v=%b rsp.v=%b d0.v=%b d1.v=%b, required all zero",
               psl_command_out.valid, read_response_out.valid,
               read_data_0_out.valid, read_data_1_out.valid);
    end
    checks++;
    if (read_buffer_status !== 2'b11 || outstanding_count !== 6'd0 || tag_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: status=%b count=%0d err=%b, required 11/0/0",
               read_buffer_status, outstanding_count, tag_error);
    end
  endtask

  task test_round_trip();
    logic [511:0] d;
    reset_dut();
    wait_init();
    set_cmd(64'h1000, 8'd3);
    step();
    clear_inputs();
    checks++;
    if (psl_command_out.valid !== 1'b1 || psl_command_out.tag !== 8'd0 ||
        psl_command_out.address !== 64'h1000 || psl_command_out.cu_id !== 8'd3) begin
      failures++;
      $display("FAIL first_cmd: v=%b tag=%0d addr=%0h cu=%0d, required 1/0/1000/3",
               psl_command_out.valid, psl_command_out.tag, psl_command_out.address,
               psl_command_out.cu_id);
    end
    checks++;
    if (read_buffer_status.full !== 1'b0 || outstanding_count !== 6'd1) begin
      failures++;
      $display("FAIL after_accept: full=%b count=%0d, required 0/1",
               read_buffer_status.full, outstanding_count);
    end
    d = {16{32'hCAFE0001}};
    psl_data_in.valid = 1'b1;
    psl_data_in.tag   = 8'd0;
    psl_data_in.data  = d;
    step();
    checks++;
    if (read_data_0_out.valid !== 1'b1 || read_data_0_out.address !== 64'h1000 ||
        read_data_0_out.cu_id !== 8'd3 || read_data_0_out.data !== d ||
        read_data_1_out.valid !== 1'b0) begin
      failures++;
      $display("FAIL beat0: v0=%b addr=%0h cu=%0d v1=%b, required 1/1000/3/0",
               read_data_0_out.valid, read_data_0_out.address, read_data_0_out.cu_id,
               read_data_1_out.valid);
    end
    psl_data_in.data_index = 1'b1;
    step();
    psl_data_in = '0;
    checks++;
    if (read_data_1_out.valid !== 1'b1 || read_data_1_out.address !== 64'h1000 ||
        read_data_1_out.cu_id !== 8'd3 || read_data_0_out.valid !== 1'b0) begin
      failures++;
      $display("FAIL beat1: v1=%b addr=%0h cu=%0d v0=%b, required 1/1000/3/0",
               read_data_1_out.valid, read_data_1_out.address, read_data_1_out.cu_id,
               read_data_0_out.valid);
    end
    set_rsp(8'd0, 8'h5A);
    step();
    clear_inputs();
    checks++;
    if (read_response_out.valid !== 1'b1 || read_response_out.address !== 64'h1000 ||
        read_response_out.cu_id !== 8'd3 || read_response_out.response !== 8'h5A ||
        outstanding_count !== 6'd0) begin
      failures++;
      $display("FAIL response: v=%b addr=%0h cu=%0d code=%0h count=%0d, required 1/1000/3/5a/0",
               read_response_out.valid, read_response_out.address, read_response_out.cu_id,
               read_response_out.response, outstanding_count);
    end
  endtask

  task test_exhaustion();
    int bad = 0;
    reset_dut();
    wait_init();
    for (int i = 0; i < 30; i++) begin
      set_cmd(64'h3000 + 64'(i), 8'd2);
      step();
      if (psl_command_out.valid !== 1'b1 || psl_command_out.tag !== 8'(i)) bad++;
    end
    clear_inputs();
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL exhaust_tags: %0d of 30 commands carried wrong tag, required 0", bad);
    end
    step();
    checks++;
    if (read_buffer_status.full !== 1'b1 || outstanding_count !== 6'd30 || tag_error !== 1'b0) begin
      failures++;
      $display("FAIL exhaust_full: full=%b count=%0d err=%b, required 1/30/0",
               read_buffer_status.full, outstanding_count, tag_error);
    end
    set_cmd(64'h4000, 8'd2);
    step();
    checks++;
    if (psl_command_out.valid !== 1'b1 || psl_command_out.tag !== 8'd30) begin
      failures++;
      $display("FAIL exhaust_31st: v=%b tag=%0d, required 1/30", psl_command_out.valid,
               psl_command_out.tag);
    end
    step();
    checks++;
    if (psl_command_out.valid !== 1'b1 || psl_command_out.tag !== 8'd31 || tag_error !== 1'b0) begin
      failures++;
      $display("FAIL exhaust_32nd: v=%b tag=%0d err=%b, required 1/31/0",
               psl_command_out.valid, psl_command_out.tag, tag_error);
    end
    step();
    clear_inputs();
    checks++;
    if (psl_command_out.valid !== 1'b0 || tag_error !== 1'b1 || outstanding_count !== 6'd32) begin
      failures++;
      $display("FAIL exhaust_drop: v=%b err=%b count=%0d, required 0/1/32",
               psl_command_out.valid, tag_error, outstanding_count);
    end
  endtask

  task test_back_to_back();
    int bad = 0;
    reset_dut();
    wait_init();
    issue_n(5);
    set_cmd(64'h5000, 8'd4);
    set_rsp(8'd2, 8'h00);
    step();
    clear_inputs();
    checks++;
    if (psl_command_out.tag !== 8'd5 || read_response_out.valid !== 1'b1 ||
        read_response_out.tag !== 8'd2 || outstanding_count !== 6'd5) begin
      failures++;
      $display("FAIL simultaneous: tag=%0d rsp.v=%b rsp.tag=%0d count=%0d, required 5/1/2/5",
               psl_command_out.tag, read_response_out.valid, read_response_out.tag,
               outstanding_count);
    end
    for (int i = 0; i < 26; i++) begin
      set_cmd(64'h6000, 8'd4);
      step();
      if (psl_command_out.tag !== 8'(6 + i)) bad++;
    end
    set_cmd(64'h6100, 8'd4);
    step();
    clear_inputs();
    checks++;
    if (bad != 0 || psl_command_out.valid !== 1'b1 || psl_command_out.tag !== 8'd2) begin
      failures++;
      $display("FAIL reuse_order: misordered=%0d last.v=%b last.tag=%0d, required 0/1/2",
               bad, psl_command_out.valid, psl_command_out.tag);
    end
  endtask

  task test_stale_tag();
    reset_dut();
    wait_init();
    issue_n(2);
    set_rsp(8'd7, 8'h00);
    step();
    clear_inputs();
    checks++;
    if (read_response_out.valid !== 1'b0 || tag_error !== 1'b1 || outstanding_count !== 6'd2) begin
      failures++;
      $display("FAIL stale_rsp: rsp.v=%b err=%b count=%0d, required 0/1/2",
               read_response_out.valid, tag_error, outstanding_count);
    end
  endtask

  task test_mid_reset();
    reset_dut();
    wait_init();
    issue_n(4);
    rstn_in = 1'b0;
    #1;
    checks++;
    if (psl_command_out !== '0 || read_buffer_status !== 2'b11 ||
        outstanding_count !== 6'd0 || tag_error !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: cmd.v=%b status=%b count=%0d err=%b, required 0/11/0/0",
               psl_command_out.valid, read_buffer_status, outstanding_count, tag_error);
    end
    step();
    rstn_in = 1'b1;
    wait_init();
    set_cmd(64'h7000, 8'd5);
    step();
    clear_inputs();
    checks++;
    if (psl_command_out.valid !== 1'b1 || psl_command_out.tag !== 8'd0) begin
      failures++;
      $display("FAIL reinit_cmd: v=%b tag=%0d, required 1/0", psl_command_out.valid,
               psl_command_out.tag);
    end
    set_rsp(8'd3, 8'h00);
    step();
    clear_inputs();
    checks++;
    if (read_response_out.valid !== 1'b0 || tag_error !== 1'b1 || outstanding_count !== 6'd1) begin
      failures++;
      $display("FAIL old_tag: rsp.v=%b err=%b count=%0d, required 0/1/1",
               read_response_out.valid, tag_error, outstanding_count);
    end
  endtask

  task test_enable();
    enabled_in = 1'b0;
    set_cmd(64'h8000, 8'd6);
    step();
    step();
    clear_inputs();
    checks++;
    if (psl_command_out.valid !== 1'b0 || outstanding_count !== 6'd1 ||
        read_buffer_status.full !== 1'b1) begin
      failures++;
      $display("FAIL disabled_cmd: v=%b count=%0d full=%b, required 0/1/1",
               psl_command_out.valid, outstanding_count, read_buffer_status.full);
    end
    set_rsp(8'd0, 8'h11);
    step();
    clear_inputs();
    checks++;
    if (read_response_out.valid !== 1'b1 || read_response_out.address !== 64'h7000 ||
        outstanding_count !== 6'd0) begin
      failures++;
      $display("FAIL disabled_drain: v=%b addr=%0h count=%0d, required 1/7000/0",
               read_response_out.valid, read_response_out.address, outstanding_count);
    end
    enabled_in = 1'b1;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_round_trip();
    test_exhaustion();
    test_back_to_back();
    test_stale_tag();
    test_mid_reset();
    test_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
